// File: rtl/sort_pkg.sv
// sort_pkg
//   Shared definitions for the selection sorter family: the controller state
//   encoding and the named sort-order constants used on the descending input.
//   No ports; imported by sort_cmp and selection_sort_engine.
package sort_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    RD_J,
    CMP,
    WR_I,
    WR_J,
    NEXT_I,
    DONE
  } sort_state_t;

  localparam logic ORDER_ASC  = 1'b0;
  localparam logic ORDER_DESC = 1'b1;

endpackage

// File: rtl/sort_cmp.sv
// sort_cmp
//   Combinational "is the candidate a better pick than the current best" test
//   for selection-style sorters. Strictly-better only, so equal keys never
//   displace the earlier element and the first occurrence wins.
// Ports
//   a       in   DATA_W  candidate value
//   b       in   DATA_W  current best value
//   desc    in   1       ORDER_DESC: larger is better, ORDER_ASC: smaller is better
//   better  out  1       candidate should replace the current best
module sort_cmp
  import sort_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              desc,
  output logic              better
);

  logic lt;
  logic gt;

  // SIGNED is elaboration-time, so only one comparator pair survives synthesis.
  always_comb begin
    if (SIGNED) begin
      lt = $signed(a) < $signed(b);
      gt = $signed(a) > $signed(b);
    end else begin
      lt = a < b;
      gt = a > b;
    end
    better = (desc == ORDER_DESC) ? gt : lt;
  end

endmodule

// File: rtl/selection_sort_engine.sv
// selection_sort_engine
//   In-place selection sort of len words starting at base_addr in an external
//   single-port memory. Each outer pass scans for the best remaining element
//   and performs at most one swap. Every memory access is a req/rdy handshake
//   so wait-state memories work unchanged.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle request, only honoured in IDLE
//   descending            sort order, latched at start
//   base_addr, len        region start and element count, latched at start
//   mem_rd, mem_wr        access requests, held until mem_rdy
//   mem_addr, mem_wdata   access address / write data, stable while pending
//   mem_rdata, mem_rdy    read data and access-complete strobe
//   busy, done            sort in progress / one-cycle completion pulse
//   swap_cnt              swaps performed by the current or last sort
module selection_sort_engine
  import sort_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              descending,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] swap_cnt
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  sort_state_t state;
  sort_state_t next_state;

  logic              desc_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] i_q;
  logic [ADDR_W-1:0] j_q;
  logic [ADDR_W-1:0] best_idx;
  logic [DATA_W-1:0] best_val;
  logic [DATA_W-1:0] cur_i_val;
  logic [DATA_W-1:0] cand;
  logic              better;
  logic              last_j;
  logic              last_i;
  logic              no_swap;

  sort_cmp #(
    .DATA_W(DATA_W),
    .SIGNED(SIGNED)
  ) u_cmp (
    .a     (cand),
    .b     (best_val),
    .desc  (desc_q),
    .better(better)
  );

  // j never exceeds len-1 and i never exceeds len-2, so with len capped at
  // 2^ADDR_W-1 both counters fit in ADDR_W bits without wrapping.
  assign last_j  = (j_q == len_q - ONE);
  assign last_i  = (i_q == len_q - TWO);
  assign no_swap = (best_idx == i_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Access states only advance on mem_rdy; CMP and NEXT_I are single-cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start) next_state = (len <= ONE) ? DONE : RD_I;
      RD_I:   if (mem_rdy) next_state = RD_J;
      RD_J:   if (mem_rdy) next_state = CMP;
      CMP:    next_state = last_j ? WR_I : RD_J;
      WR_I: begin
        if (no_swap) begin
          next_state = NEXT_I;
        end else if (mem_rdy) begin
          next_state = WR_J;
        end
      end
      WR_J:   if (mem_rdy) next_state = NEXT_I;
      NEXT_I: next_state = last_i ? DONE : RD_I;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers. The value originally at position i is kept in
  // cur_i_val so the swap can finish without re-reading memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      desc_q    <= ORDER_ASC;
      base_q    <= '0;
      len_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      cur_i_val <= '0;
      cand      <= '0;
      swap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            desc_q   <= descending;
            base_q   <= base_addr;
            len_q    <= len;
            i_q      <= '0;
            swap_cnt <= '0;
          end
        end
        RD_I: begin
          if (mem_rdy) begin
            best_val  <= mem_rdata;
            cur_i_val <= mem_rdata;
            best_idx  <= i_q;
            j_q       <= i_q + ONE;
          end
        end
        RD_J: begin
          if (mem_rdy) cand <= mem_rdata;
        end
        CMP: begin
          if (better) begin
            best_val <= cand;
            best_idx <= j_q;
          end
          if (!last_j) j_q <= j_q + ONE;
        end
        WR_J: begin
          if (mem_rdy) swap_cnt <= swap_cnt + ONE;
        end
        NEXT_I: begin
          if (!last_i) i_q <= i_q + ONE;
        end
        default: ;
      endcase
    end
  end

  // Memory port mux. Outputs depend only on state and registers, so address
  // and data stay put for as long as a request waits for mem_rdy.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
    case (state)
      RD_I: begin
        mem_rd   = 1'b1;
        mem_addr = base_q + i_q;
      end
      RD_J: begin
        mem_rd   = 1'b1;
        mem_addr = base_q + j_q;
      end
      WR_I: begin
        if (!no_swap) begin
          mem_wr    = 1'b1;
          mem_addr  = base_q + i_q;
          mem_wdata = best_val;
        end
      end
      WR_J: begin
        mem_wr    = 1'b1;
        mem_addr  = base_q + best_idx;
        mem_wdata = cur_i_val;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_selection_sort_engine.sv
// tb_selection_sort_engine
//   Drives an unsigned and a signed sorter instance against one shared
//   behavioural memory with 0-3 random wait states, and compares results with
//   an array-level selection sort model.
module tb_selection_sort_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        descending;
  logic        sel;
  logic [7:0]  base_addr;
  logic [7:0]  len;

  logic        rd0, wr0, rdy0, busy0, done0, start0;
  logic [7:0]  addr0, swap0;
  logic [15:0] wdata0;
  logic        rd1, wr1, rdy1, busy1, done1, start1;
  logic [7:0]  addr1, swap1;
  logic [15:0] wdata1;

  logic        req_rd, req_wr, rdy_s;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata, rdata;

  logic [15:0] mem [256];
  logic [15:0] model_mem [256];
  logic [1:0]  wait_left = 2'd0;
  int          max_wait = 0;
  int          write_count = 0;
  int          read_count = 0;
  int          done_count = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign start0    = start && !sel;
  assign start1    = start && sel;
  assign req_rd    = sel ? rd1 : rd0;
  assign req_wr    = sel ? wr1 : wr0;
  assign req_addr  = sel ? addr1 : addr0;
  assign req_wdata = sel ? wdata1 : wdata0;
  assign rdata     = mem[req_addr];
  assign rdy_s     = (max_wait == 0) ? 1'b1 : ((req_rd || req_wr) && wait_left == 2'd0);
  assign rdy0      = rdy_s && !sel;
  assign rdy1      = rdy_s && sel;

  selection_sort_engine #(.DATA_W(16), .ADDR_W(8), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .start(start0), .descending(descending),
    .base_addr(base_addr), .len(len), .mem_rd(rd0), .mem_wr(wr0),
    .mem_addr(addr0), .mem_wdata(wdata0), .mem_rdata(rdata), .mem_rdy(rdy0),
    .busy(busy0), .done(done0), .swap_cnt(swap0)
  );

  selection_sort_engine #(.DATA_W(16), .ADDR_W(8), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start1), .descending(descending),
    .base_addr(base_addr), .len(len), .mem_rd(rd1), .mem_wr(wr1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata), .mem_rdy(rdy1),
    .busy(busy1), .done(done1), .swap_cnt(swap1)
  );

  // Memory model: an access completes in the cycle rdy is high, then a fresh
  // random wait is drawn for the next access.
  always @(posedge clk) begin
    if ((req_rd || req_wr) && rdy_s) begin
      if (req_wr) begin
        mem[req_addr] = req_wdata;
        write_count   = write_count + 1;
      end else begin
        read_count = read_count + 1;
      end
      wait_left <= (max_wait == 0) ? 2'd0 : 2'($urandom_range(0, max_wait));
    end else if ((req_rd || req_wr) && wait_left != 2'd0) begin
      wait_left <= wait_left - 2'd1;
    end
  end

  // Protocol monitor: a pending request must hold address/data/kind, and a
  // read and a write are never requested together.
  logic        pend_q = 1'b0;
  logic        prev_rd, prev_wr;
  logic [7:0]  prev_addr;
  logic [15:0] prev_wdata;

  always @(negedge clk) begin
    if (done0 || done1) done_count = done_count + 1;
    total = total + 1;
    assert (!(req_rd && req_wr)) else begin
      bad = bad + 1;
      $error("[TB] FAIL rd_wr_exclusive: observed rd=%0b wr=%0b expected not both", req_rd, req_wr);
    end
    if (pend_q && !rst) begin
      total = total + 1;
      assert (req_rd === prev_rd && req_wr === prev_wr && req_addr === prev_addr &&
              (!req_wr || req_wdata === prev_wdata)) else begin
        bad = bad + 1;
        $error("[TB] FAIL hold_stable: observed rd=%0b wr=%0b addr=%0h wdata=%0h expected rd=%0b wr=%0b addr=%0h wdata=%0h",
               req_rd, req_wr, req_addr, req_wdata, prev_rd, prev_wr, prev_addr, prev_wdata);
      end
    end
    pend_q     = (req_rd || req_wr) && !rdy_s && !rst;
    prev_rd    = req_rd;
    prev_wr    = req_wr;
    prev_addr  = req_addr;
    prev_wdata = req_wdata;
  end

  function automatic int key_of(logic [15:0] v, bit sgn);
    return sgn ? int'($signed(v)) : int'({16'b0, v});
  endfunction

  // Plain selection sort over the model image; returns the number of swaps.
  function automatic int model_sort(bit desc_in, bit sgn, logic [7:0] base_in, int n);
    int swaps = 0;
    for (int i = 0; i < n - 1; i++) begin
      int best = i;
      for (int j = i + 1; j < n; j++) begin
        int kj = key_of(model_mem[8'(int'(base_in) + j)], sgn);
        int kb = key_of(model_mem[8'(int'(base_in) + best)], sgn);
        if (desc_in ? (kj > kb) : (kj < kb)) best = j;
      end
      if (best != i) begin
        logic [15:0] tmp = model_mem[8'(int'(base_in) + i)];
        model_mem[8'(int'(base_in) + i)]    = model_mem[8'(int'(base_in) + best)];
        model_mem[8'(int'(base_in) + best)] = tmp;
        swaps++;
      end
    end
    return swaps;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one start and waits (bounded) for done. A second start with
  // different arguments is optionally pulsed while the sort is busy.
  task automatic apply_stimulus(input bit use_signed, input bit desc_in, input logic [7:0] base_in,
                                input logic [7:0] len_in, input bit poke,
                                output int cycles, output logic busy_first);
    @(negedge clk);
    sel        = use_signed;
    descending = desc_in;
    base_addr  = base_in;
    len        = len_in;
    start      = 1'b1;
    done_count = 0;
    @(posedge clk);
    #1;
    start      = 1'b0;
    cycles     = 1;
    busy_first = use_signed ? busy1 : busy0;
    while ((use_signed ? done1 : done0) !== 1'b1 && cycles < 3000) begin
      if (poke && cycles == 4) begin
        start      = 1'b1;
        base_addr  = base_in + 8'd7;
        len        = 8'd3;
        descending = !desc_in;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    check_output("done_seen", {31'b0, (use_signed ? done1 : done0)}, 32'd1);
    check_output("busy_at_done", {31'b0, (use_signed ? busy1 : busy0)}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_and_check(input string tag, input bit use_signed, input bit desc_in,
                               input logic [7:0] base_in, input logic [7:0] len_in,
                               input bit poke, input bit check_lat);
    int          exp_swaps;
    int          exp_cycles;
    int          cycles;
    int          mism;
    int          n;
    logic        busy_first;
    n = int'(len_in);
    for (int k = 0; k < 256; k++) model_mem[k] = mem[k];
    exp_swaps = model_sort(desc_in, use_signed, base_in, n);
    exp_cycles = (n < 2) ? 1 : n * (n - 1) + 3 * (n - 1) + exp_swaps + 1;
    write_count = 0;
    read_count  = 0;
    apply_stimulus(use_signed, desc_in, base_in, len_in, poke, cycles, busy_first);
    mism = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== model_mem[k]) mism++;
    check_output({tag, "_done_pulses"}, done_count, 32'd1);
    check_output({tag, "_swap_cnt"}, {24'b0, (use_signed ? swap1 : swap0)}, exp_swaps);
    check_output({tag, "_mem_image_mismatches"}, mism, 32'd0);
    check_output({tag, "_busy_after_start"}, {31'b0, busy_first}, {31'b0, (n >= 2)});
    if (check_lat) check_output({tag, "_latency"}, cycles, exp_cycles);
  endtask

  initial begin
    logic [15:0] t1_in  [5] = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd3};
    logic [15:0] t1_out [5] = '{16'd1, 16'd3, 16'd3, 16'd5, 16'd9};
    logic [15:0] t2_in  [4] = '{16'hFFFE, 16'd7, 16'd0, 16'hFFF8};
    logic [15:0] t2_sgn [4] = '{16'd7, 16'd0, 16'hFFFE, 16'hFFF8};
    logic [15:0] t2_uns [4] = '{16'hFFFE, 16'hFFF8, 16'd7, 16'd0};
    logic [15:0] save_fd, save_02;
    logic [7:0]  rb;
    int          rn;
    bit          found;
    bit          prev_w;
    int          guard;

    start = 1'b0; descending = 1'b0; sel = 1'b0; base_addr = '0; len = '0; rst = 1'b1;
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset values");
    check_output("rst_mem_rd", {31'b0, rd0}, 32'd0);
    check_output("rst_mem_wr", {31'b0, wr0}, 32'd0);
    check_output("rst_mem_addr", {24'b0, addr0}, 32'd0);
    check_output("rst_mem_wdata", {16'b0, wdata0}, 32'd0);
    check_output("rst_busy", {31'b0, busy0}, 32'd0);
    check_output("rst_done", {31'b0, done0}, 32'd0);
    check_output("rst_swap_cnt", {24'b0, swap0}, 32'd0);
    check_output("rst_signed_busy", {31'b0, busy1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed ascending sort with wait states");
    max_wait = 3;
    for (int k = 0; k < 5; k++) mem[k] = t1_in[k];
    run_and_check("t1", 1'b0, 1'b0, 8'h00, 8'd5, 1'b0, 1'b0);
    check_output("t1_swap_const", {24'b0, swap0}, 32'd2);
    for (int k = 0; k < 5; k++) check_output("t1_word", {16'b0, mem[k]}, {16'b0, t1_out[k]});

    $display("[TB] descending signed and unsigned");
    for (int k = 0; k < 4; k++) mem[8'h40 + k] = t2_in[k];
    run_and_check("t2s", 1'b1, 1'b1, 8'h40, 8'd4, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) check_output("t2s_word", {16'b0, mem[8'h40 + k]}, {16'b0, t2_sgn[k]});
    for (int k = 0; k < 4; k++) mem[8'h40 + k] = t2_in[k];
    run_and_check("t2u", 1'b0, 1'b1, 8'h40, 8'd4, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) check_output("t2u_word", {16'b0, mem[8'h40 + k]}, {16'b0, t2_uns[k]});

    $display("[TB] len 0 and len 1");
    for (int l = 0; l < 2; l++) begin
      run_and_check("t3", 1'b0, 1'b0, 8'h20, 8'(l), 1'b0, 1'b1);
      check_output("t3_no_reads", read_count, 32'd0);
      check_output("t3_no_writes", write_count, 32'd0);
    end

    $display("[TB] region wrapping past the top of memory");
    for (int k = 0; k < 4; k++) mem[8'(8'hFE + k)] = 16'($urandom);
    save_fd = mem[8'hFD];
    save_02 = mem[8'h02];
    run_and_check("t4", 1'b0, 1'b0, 8'hFE, 8'd4, 1'b0, 1'b0);
    check_output("t4_neigh_fd", {16'b0, mem[8'hFD]}, {16'b0, save_fd});
    check_output("t4_neigh_02", {16'b0, mem[8'h02]}, {16'b0, save_02});

    $display("[TB] already sorted, zero-wait latency");
    max_wait = 0;
    for (int k = 0; k < 4; k++) mem[8'h80 + k] = 16'(k + 1);
    run_and_check("t5", 1'b0, 1'b0, 8'h80, 8'd4, 1'b0, 1'b1);
    check_output("t5_no_writes", write_count, 32'd0);
    check_output("t5_latency_const", {24'b0, 8'd22}, 32'd22 + {24'b0, swap0});

    $display("[TB] start pulsed while busy");
    max_wait = 2;
    for (int k = 0; k < 6; k++) mem[8'h60 + k] = 16'($urandom_range(0, 9));
    run_and_check("t6", 1'b0, 1'b0, 8'h60, 8'd6, 1'b1, 1'b0);

    $display("[TB] randomized sorts");
    for (int r = 0; r < 10; r++) begin
      max_wait = int'($urandom_range(0, 3));
      rb = 8'($urandom);
      rn = int'($urandom_range(2, 12));
      for (int k = 0; k < rn; k++)
        mem[8'(int'(rb) + k)] = (r % 2 == 1) ? 16'($urandom_range(0, 5)) : 16'($urandom);
      run_and_check("rnd", 1'($urandom), 1'($urandom), rb, 8'(rn), 1'b0, max_wait == 0);
    end

    $display("[TB] reset during the second write of a swap");
    max_wait = 0;
    for (int k = 0; k < 4; k++) mem[8'h10 + k] = 16'(4 - k);
    @(negedge clk);
    sel = 1'b0; descending = 1'b0; base_addr = 8'h10; len = 8'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    found  = 1'b0;
    prev_w = 1'b0;
    guard  = 0;
    while (!found && guard < 60) begin
      @(negedge clk);
      if (wr0 && prev_w) found = 1'b1;
      else begin
        prev_w = wr0;
        guard++;
      end
    end
    check_output("t7_reached_wr_j", {31'b0, found}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("t7_mem_rd", {31'b0, rd0}, 32'd0);
    check_output("t7_mem_wr", {31'b0, wr0}, 32'd0);
    check_output("t7_mem_addr", {24'b0, addr0}, 32'd0);
    check_output("t7_mem_wdata", {16'b0, wdata0}, 32'd0);
    check_output("t7_busy", {31'b0, busy0}, 32'd0);
    check_output("t7_done", {31'b0, done0}, 32'd0);
    check_output("t7_swap_cnt", {24'b0, swap0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] recovery sort after reset");
    for (int k = 0; k < 5; k++) mem[8'h30 + k] = 16'($urandom);
    run_and_check("t8", 1'b0, 1'b1, 8'h30, 8'd5, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
